// File: rtl/ps2_key_decoder_if.sv
// Byte-stream input and key-event output bundle of the PS/2 scan-code decoder.
interface ps2_key_decoder_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       evt_ready;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       ovf_clr;
  logic       overflow;

  modport master (
    output rx_byte, rx_valid, evt_ready, ovf_clr,
    input  evt_valid, evt_code, evt_ext, evt_break, overflow
  );

  modport slave (
    input  rx_byte, rx_valid, evt_ready, ovf_clr,
    output evt_valid, evt_code, evt_ext, evt_break, overflow
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// Scan-code set 2 parser: turns PS/2 byte sequences into key events,
// filters typematic repeats and queues events in a show-ahead FIFO.
module ps2_key_decoder #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned FILTER_REPEAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  ps2_key_decoder_if.slave  bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = 10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_PAUSE   = 3'd4
  } state_t;

  state_t          state;
  logic [2:0]      skip_cnt;
  logic            held_valid;
  logic [8:0]      held_key;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            evt_valid_q;
  logic            overflow_q;

  logic            emit_c;
  logic            pause_c;
  logic            ev_ext_c;
  logic            ev_brk_c;
  logic [7:0]      ev_code_c;
  logic            housekeep_c;
  logic            fake_shift_c;
  logic            held_match_c;
  logic            push_c;
  logic            pop_c;
  logic            full_c;
  logic            wr_en_c;
  logic            drop_c;
  logic [PW-1:0]   wr_ptr_nxt_c;
  logic [PW-1:0]   rd_ptr_nxt_c;

  // Byte classification and event generation for the current strobe
  always_comb begin
    emit_c       = 1'b0;
    pause_c      = 1'b0;
    ev_ext_c     = 1'b0;
    ev_brk_c     = 1'b0;
    ev_code_c    = bus.rx_byte;
    housekeep_c  = (bus.rx_byte == 8'hAA) || (bus.rx_byte == 8'hFA) ||
                   (bus.rx_byte == 8'hFE) || (bus.rx_byte == 8'hEE) ||
                   (bus.rx_byte == 8'h00) || (bus.rx_byte == 8'hFF);
    fake_shift_c = (bus.rx_byte == 8'h12) || (bus.rx_byte == 8'h59);
    if (bus.rx_valid) begin
      case (state)
        S_IDLE: begin
          if (bus.rx_byte != 8'hE0 && bus.rx_byte != 8'hF0 &&
              bus.rx_byte != 8'hE1 && !housekeep_c)
            emit_c = 1'b1;
        end
        S_EXT: begin
          ev_ext_c = 1'b1;
          if (bus.rx_byte != 8'hF0 && !fake_shift_c) emit_c = 1'b1;
        end
        S_BRK: begin
          ev_brk_c = 1'b1;
          emit_c   = 1'b1;
        end
        S_EXT_BRK: begin
          ev_ext_c = 1'b1;
          ev_brk_c = 1'b1;
          if (!fake_shift_c) emit_c = 1'b1;
        end
        S_PAUSE: begin
          if (skip_cnt == 3'd1) begin
            emit_c    = 1'b1;
            pause_c   = 1'b1;
            ev_ext_c  = 1'b1;
            ev_code_c = 8'h77;
          end
        end
        default: emit_c = 1'b0;
      endcase
    end
  end

  // Repeat filter and FIFO control
  always_comb begin
    held_match_c = held_valid && (held_key == {ev_ext_c, ev_code_c});
    push_c       = emit_c &&
                   (pause_c || ev_brk_c || !((FILTER_REPEAT != 0) && held_match_c));
    pop_c        = evt_valid_q && bus.evt_ready;
    full_c       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    wr_en_c      = push_c && (!full_c || pop_c);
    drop_c       = push_c && full_c && !pop_c;
    wr_ptr_nxt_c = wr_en_c ? wr_ptr + PW'(1) : wr_ptr;
    rd_ptr_nxt_c = pop_c   ? rd_ptr + PW'(1) : rd_ptr;
  end

  // Parser state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      skip_cnt <= 3'd0;
    end else if (bus.rx_valid) begin
      case (state)
        S_IDLE: begin
          if (bus.rx_byte == 8'hE0)      state <= S_EXT;
          else if (bus.rx_byte == 8'hF0) state <= S_BRK;
          else if (bus.rx_byte == 8'hE1) begin
            state    <= S_PAUSE;
            skip_cnt <= 3'd7;
          end
        end
        S_EXT:     state <= (bus.rx_byte == 8'hF0) ? S_EXT_BRK : S_IDLE;
        S_BRK:     state <= S_IDLE;
        S_EXT_BRK: state <= S_IDLE;
        S_PAUSE: begin
          if (skip_cnt == 3'd1) state <= S_IDLE;
          else                  skip_cnt <= skip_cnt - 3'd1;
        end
        default:   state <= S_IDLE;
      endcase
    end
  end

  // Held-key tracking; Pause never touches it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_valid <= 1'b0;
      held_key   <= '0;
    end else if ((FILTER_REPEAT != 0) && emit_c && !pause_c) begin
      if (!ev_brk_c && !held_match_c) begin
        held_valid <= 1'b1;
        held_key   <= {ev_ext_c, ev_code_c};
      end else if (ev_brk_c && held_match_c) begin
        held_valid <= 1'b0;
      end
    end
  end

  // Event FIFO storage, pointers and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      evt_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (wr_en_c) mem[wr_ptr[AW-1:0]] <= {ev_ext_c, ev_brk_c, ev_code_c};
      wr_ptr      <= wr_ptr_nxt_c;
      rd_ptr      <= rd_ptr_nxt_c;
      evt_valid_q <= (wr_ptr_nxt_c != rd_ptr_nxt_c);
      if (drop_c)           overflow_q <= 1'b1;
      else if (bus.ovf_clr) overflow_q <= 1'b0;
    end
  end

  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_ext   = mem[rd_ptr[AW-1:0]][9];
  assign bus.evt_break = mem[rd_ptr[AW-1:0]][8];
  assign bus.evt_code  = mem[rd_ptr[AW-1:0]][7:0];
  assign bus.overflow  = overflow_q;
endmodule
